// File: rtl/video_mode_sched.sv
// video_mode_sched
// Frame-synchronous scheduler for the test-pattern generator in the DVI/HDMI
// TX path. It watches VS from the timing generator and steps the pattern
// mode, and the colour list while in single-colour mode. A step can come
// from an automatic frame count or from a manual request. Every change is
// applied at a frame boundary, so no frame is torn.
//
// Ports:
//   I_pxl_clk    pixel clock
//   I_rst_n      asynchronous active-low reset
//   I_vs         VS from the timing generator (polarity set by VS_POL)
//   I_next       manual step request, single-cycle pulse
//   I_auto_en    1 = step automatically every FRAMES_PER_STEP frames
//   I_hold       1 = freeze stepping and the step counter
//   O_mode       pattern mode to the generator
//   O_single_r/g/b  single-colour value
//   O_mode_chg   one-cycle pulse when the mode or the colour changes
//   O_frame_cnt  frames counted since sync after reset, wraps at 16 bits
//   O_pending    a manual step is queued for the next frame boundary
module video_mode_sched #(
  parameter int unsigned FRAMES_PER_STEP = 256,
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned SINGLE_MODE     = 3,
  parameter bit          VS_POL          = 1'b1
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst_n,
  input  logic        I_vs,
  input  logic        I_next,
  input  logic        I_auto_en,
  input  logic        I_hold,
  output logic [2:0]  O_mode,
  output logic [7:0]  O_single_r,
  output logic [7:0]  O_single_g,
  output logic [7:0]  O_single_b,
  output logic        O_mode_chg,
  output logic [15:0] O_frame_cnt,
  output logic        O_pending
);

  localparam logic [15:0] STEP_LAST  = 16'(FRAMES_PER_STEP - 1);
  localparam logic [2:0]  LAST_MODE  = 3'(NUM_MODES - 1);
  localparam logic [2:0]  SINGLE_M   = 3'(SINGLE_MODE);
  localparam logic [2:0]  LAST_COLOR = 3'd7;
  localparam logic        VS_IDLE    = ~VS_POL;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        vs_r;
  logic        fe;
  logic [15:0] step_cnt, step_cnt_nxt;
  logic [15:0] frame_cnt_nxt;
  logic [2:0]  color_idx, color_nxt;
  logic [2:0]  mode_nxt;
  logic        pending_nxt;
  logic        auto_hit;
  logic        step_fire;
  logic [23:0] rgb_nxt;

  function automatic logic [23:0] color_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    color_rgb = 24'hFF0000;
      3'd1:    color_rgb = 24'h00FF00;
      3'd2:    color_rgb = 24'h0000FF;
      3'd3:    color_rgb = 24'hFFFFFF;
      3'd4:    color_rgb = 24'hFFFF00;
      3'd5:    color_rgb = 24'h00FFFF;
      3'd6:    color_rgb = 24'hFF00FF;
      default: color_rgb = 24'h000000;
    endcase
  endfunction

  // Frame end is the deasserting edge of VS, whichever polarity it has.
  assign fe = VS_POL ? (vs_r & ~I_vs) : (~vs_r & I_vs);

  assign rgb_nxt = color_rgb(color_nxt);

  // Next-state logic. The new mode/colour is loaded on the edge that ends
  // the frame-end cycle, so it is already visible during S_STEP. Pending is
  // reloaded with I_next at that same edge, so a request arriving in the
  // firing cycle survives for the following frame.
  always_comb begin
    state_nxt     = state;
    step_cnt_nxt  = step_cnt;
    frame_cnt_nxt = O_frame_cnt;
    pending_nxt   = O_pending | I_next;
    mode_nxt      = O_mode;
    color_nxt     = color_idx;
    auto_hit      = 1'b0;
    step_fire     = 1'b0;

    case (state)
      S_SYNC: begin
        if (fe) begin
          state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (fe) begin
          frame_cnt_nxt = O_frame_cnt + 16'd1;
          if (!I_hold && I_auto_en) begin
            auto_hit     = (step_cnt == STEP_LAST);
            step_cnt_nxt = step_cnt + 16'd1;
          end
          if (!I_hold && (O_pending || auto_hit)) begin
            step_fire    = 1'b1;
            state_nxt    = S_STEP;
            step_cnt_nxt = 16'd0;
            pending_nxt  = I_next;
            // Walk the colour list while in single-colour mode; any mode
            // advance restarts the list at colour 0.
            if (O_mode == SINGLE_M && color_idx != LAST_COLOR) begin
              color_nxt = color_idx + 3'd1;
            end else begin
              color_nxt = 3'd0;
              mode_nxt  = (O_mode == LAST_MODE) ? 3'd0 : O_mode + 3'd1;
            end
          end
        end
      end

      S_STEP: begin
        state_nxt = S_RUN;
      end

      default: begin
        state_nxt = S_SYNC;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= S_SYNC;
      vs_r        <= VS_IDLE;
      step_cnt    <= 16'd0;
      O_frame_cnt <= 16'd0;
      O_pending   <= 1'b0;
      O_mode      <= 3'd0;
      color_idx   <= 3'd0;
      O_single_r  <= 8'hFF;
      O_single_g  <= 8'h00;
      O_single_b  <= 8'h00;
      O_mode_chg  <= 1'b0;
    end else begin
      state       <= state_nxt;
      vs_r        <= I_vs;
      step_cnt    <= step_cnt_nxt;
      O_frame_cnt <= frame_cnt_nxt;
      O_pending   <= pending_nxt;
      O_mode      <= mode_nxt;
      color_idx   <= color_nxt;
      O_single_r  <= rgb_nxt[23:16];
      O_single_g  <= rgb_nxt[15:8];
      O_single_b  <= rgb_nxt[7:0];
      O_mode_chg  <= step_fire;
    end
  end

endmodule
